// File: rtl/hilo_muldiv.sv
// Multi-cycle signed multiply/divide feeding the HI/LO register pair.
// Optional unsigned mode: define HILO_MULDIV_UNSIGNED_EN to add op_unsigned.
module hilo_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  op,
`ifdef HILO_MULDIV_UNSIGNED_EN
  input  logic                  op_unsigned,
`endif
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  HIin,
  output logic                  LOin,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [DATA_WIDTH-1:0] result_lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } state_t;

  state_t state, next;

  logic          uns_in;
  logic          uns_r;
  logic          sa;
  logic          b_top;
  logic          dbz;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_lat;
  logic [W:0]    m;
  logic [W:0]    a_reg;
  logic [W-1:0]  q_reg;
  logic          q_m1;
  logic [W+1:0]  r_reg;
  logic [W-1:0]  d;

`ifdef HILO_MULDIV_UNSIGNED_EN
  assign uns_in = op_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  logic [W-1:0] mag_a, mag_b;

  always_comb begin
    mag_a = operand_a;
    mag_b = operand_b;
    if (!uns_in && operand_a[W-1]) mag_a = -operand_a;
    if (!uns_in && operand_b[W-1]) mag_b = -operand_b;
  end

  logic [W:0] booth_sum;

  always_comb begin
    booth_sum = a_reg;
    unique case ({q_reg[0], q_m1})
      2'b01:   booth_sum = a_reg + m;
      2'b10:   booth_sum = a_reg - m;
      default: booth_sum = a_reg;
    endcase
  end

  logic [W+1:0] r_sh, r_new;

  always_comb begin
    r_sh  = {r_reg[W:0], q_reg[W-1]};
    r_new = r_reg[W+1] ? r_sh + {2'b00, d}
                       : r_sh - {2'b00, d};
  end

  // Remainder fits W bits once corrected, so low bits suffice
  logic [W-1:0] rem;
  logic         neg_q;
  logic [W-1:0] mul_hi;

  always_comb begin
    rem    = r_reg[W+1] ? r_reg[W-1:0] + d : r_reg[W-1:0];
    neg_q  = sa ^ (b_top & ~uns_r);
    mul_hi = a_reg[W-1:0] + ({W{uns_r & b_top}} & m[W-1:0]);
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!op)                 next = MUL;
          else if (operand_b == 0) next = FIX;
          else                     next = DIV;
        end
      end
      MUL:     if (cnt == 0) next = DONE;
      DIV:     if (cnt == 0) next = FIX;
      FIX:     next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      uns_r     <= 1'b0;
      sa        <= 1'b0;
      b_top     <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      a_lat     <= '0;
      m         <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      q_m1      <= 1'b0;
      r_reg     <= '0;
      d         <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            uns_r <= uns_in;
            sa    <= ~uns_in & operand_a[W-1];
            b_top <= operand_b[W-1];
            dbz   <= 1'b0;
            cnt   <= CW'(W);
            a_lat <= operand_a;
            a_reg <= '0;
            q_m1  <= 1'b0;
            r_reg <= '0;
            m     <= {~uns_in & operand_a[W-1], operand_a};
            d     <= mag_b;
            q_reg <= op ? mag_a : operand_b;
          end
        end
        MUL: begin
          if (cnt != 0) begin
            a_reg <= {booth_sum[W], booth_sum[W:1]};
            q_reg <= {booth_sum[0], q_reg[W-1:1]};
            q_m1  <= q_reg[0];
            cnt   <= cnt - 1'b1;
          end else begin
            // Unsigned multiplier with msb set was consumed as negative
            result_hi <= mul_hi;
            result_lo <= q_reg;
          end
        end
        DIV: begin
          if (cnt != 0) begin
            r_reg <= r_new;
            q_reg <= {q_reg[W-2:0], ~r_new[W+1]};
            cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (d == 0) begin
            dbz       <= 1'b1;
            result_hi <= a_lat;
            result_lo <= '1;
          end else begin
            result_hi <= sa ? -rem : rem;
            result_lo <= neg_q ? -q_reg : q_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign HIin        = done;
  assign LOin        = done;
  assign div_by_zero = done & dbz;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table, random ops vs.
// an arithmetic reference model, and reset/busy corner sequences.
module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        op_unsigned = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, div_by_zero, HIin, LOin;
  logic [31:0] result_hi, result_lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hilo_muldiv #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .op         (op),
`ifdef HILO_MULDIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .HIin       (HIin),
    .LOin       (LOin),
    .result_hi  (result_hi),
    .result_lo  (result_lo)
  );

  typedef struct {
    string       nm;
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic o, input logic u,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz, output int lat);
    logic [63:0] p;
    int sa, sb;
    dz = 1'b0;
    if (!o) begin
      if (u) p = {32'd0, a} * {32'd0, b};
      else   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      hi  = p[63:32];
      lo  = p[31:0];
      lat = 33;
    end else if (b == 0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dz  = 1'b1;
      lat = 1;
    end else begin
      lat = 34;
      if (u) begin
        lo = a / b;
        hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'h0;
      end else begin
        sa = a;
        sb = b;
        lo = sa / sb;
        hi = sa % sb;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic o, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat);
    int lat;
    @(negedge clock);
    start = 1'b1; op = o; op_unsigned = u;
    operand_a = a; operand_b = b;
    @(posedge clock);
    #1 start = 1'b0;
    check({nm, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
      if (done) break;
    end
    check({nm, ".lat"}, lat, elat);
    check({nm, ".hi"}, result_hi, ehi);
    check({nm, ".lo"}, result_lo, elo);
    check({nm, ".dbz"}, 32'(div_by_zero), 32'(edz));
    check({nm, ".strobe"}, {30'd0, HIin, LOin}, 32'd3);
    @(posedge clock);
    #1;
    check({nm, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (done || HIin || LOin) n++;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] a, b, hi, lo;
    logic        o, u, dz;
    int          lat, n;

    tbl.push_back('{"mul7xm3", 0, 32'd7, 32'hFFFF_FFFD,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33});
    tbl.push_back('{"mulmnxmn", 0, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0, 0, 33});
    tbl.push_back('{"mulmaxsq", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                    32'h3FFF_FFFF, 32'h0000_0001, 0, 33});
    tbl.push_back('{"mulm1m1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'h0, 32'h1, 0, 33});
    tbl.push_back('{"mulzero", 0, 32'h0, 32'd12345,
                    32'h0, 32'h0, 0, 33});
    tbl.push_back('{"divm7d2", 1, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34});
    tbl.push_back('{"divmnm1", 1, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0, 32'h8000_0000, 0, 34});
    tbl.push_back('{"div100d7", 1, 32'd100, 32'd7,
                    32'd2, 32'd14, 0, 34});
    tbl.push_back('{"div7dm2", 1, 32'd7, 32'hFFFF_FFFE,
                    32'd1, 32'hFFFF_FFFD, 0, 34});
    tbl.push_back('{"div5d0", 1, 32'd5, 32'd0,
                    32'd5, 32'hFFFF_FFFF, 1, 1});

    #2;
    check("rst.ctl", {27'd0, busy, done, div_by_zero, HIin, LOin}, 32'd0);
    check("rst.hi", result_hi, 32'd0);
    check("rst.lo", result_lo, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].nm, tbl[i].o, 1'b0, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat);

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
`ifdef HILO_MULDIV_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
`else
      u = 1'b0;
`endif
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(o, u, a, b, hi, lo, dz, lat);
      run_op($sformatf("rnd%0d", i), o, u, a, b, hi, lo, dz, lat);
    end

`ifdef HILO_MULDIV_UNSIGNED_EN
    run_op("umul", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,
           32'd1, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("udiv", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2,
           32'd1, 32'h7FFF_FFFF, 1'b0, 34);
`endif

    // Reset in the middle of a multiply
    run_op("pre", 1'b0, 1'b0, 32'd9, 32'd11, 32'd0, 32'd99, 1'b0, 33);
    @(negedge clock);
    start = 1'b1; op = 1'b0; operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 clear = 1'b0;
    #1;
    check("mid.ctl", {27'd0, busy, done, div_by_zero, HIin, LOin}, 32'd0);
    check("mid.hi", result_hi, 32'd0);
    check("mid.lo", result_lo, 32'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    count_dones(40, n);
    check("mid.nostrobe", n, 0);
    check("mid.lo2", result_lo, 32'd0);

    run_op("fresh", 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);

    // Starts while busy and during the done cycle are dropped
    @(negedge clock);
    start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    lat = 6;
    while (lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
      if (done) break;
    end
    check("ign.lat", lat, 33);
    check("ign.hi", result_hi, 32'd0);
    check("ign.lo", result_lo, 32'd15);
    check("ign.dbz", 32'(div_by_zero), 32'd0);
    start = 1'b1; op = 1'b1; operand_a = 32'd77; operand_b = 32'd0;
    @(posedge clock);
    #1 start = 1'b0;
    check("ign.done_start", 32'(busy), 32'd0);
    count_dones(40, n);
    check("ign.noqueue", n, 0);
    check("ign.lo2", result_lo, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
